// File: rtl/icache_pkg.sv
// Shared widths, default geometry and FSM state type for the instruction cache.
package icache_pkg;
  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DEF_LINES = 32;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_RESPOND
  } state_t;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage: data words, tags and valid bits.
// Reads are combinational; writes land on the clock edge; valid bits also clear asynchronously.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int TAG_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  input  logic [$clog2(WORDS)-1:0] rd_word,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TAG_W-1:0]         rd_tag,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [$clog2(WORDS)-1:0] wr_word,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     tag_we,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     valid_set
);
  logic [DATA_W-1:0] data_mem [LINES*WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  assign rd_data  = data_mem[{rd_idx, rd_word}];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
    if (tag_we) tag_mem[wr_idx] <= tag_in;
  end

  // Flush wins over a refill completing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (clr) valid <= '0;
    else if (valid_set) valid[wr_idx] <= 1'b1;
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with word-at-a-time line refill.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rw_flag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        write_mask,
  output logic [INST_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done
);
  localparam int WRD_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - WRD_W - IDX_W;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [WRD_W-1:0]  cnt;
  logic              flushed;
  logic              refill_we, last_word, load;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, hit;
  logic [WRD_W-1:0]  req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused;

  assign req_word = req_addr[WRD_W+1:2];
  assign req_idx  = req_addr[WRD_W+IDX_W+1:WRD_W+2];
  assign req_tag  = req_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign load     = rw_flag[0] && !busy;
  assign mem_addr = {req_addr[ADDR_W-1:WRD_W+2], cnt, 2'b00};
  assign unused   = ^{write_data, write_mask, req_addr[1:0]};

  icache_array #(.LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .rd_idx   (req_idx),
    .rd_word  (req_word),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (refill_we),
    .wr_idx   (req_idx),
    .wr_word  (cnt),
    .wr_data  (mem_rdata),
    .tag_we   (last_word),
    .tag_in   (req_tag),
    .valid_set(last_word && !flushed)
  );

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    read_data = '0;
    refill_we = 1'b0;
    last_word = 1'b0;
    case (state)
      ST_IDLE: if (rw_flag[0]) state_nx = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit) begin
          done      = 1'b1;
          read_data = rd_data;
          state_nx  = rw_flag[0] ? ST_LOOKUP : ST_IDLE;
        end else begin
          busy     = 1'b1;
          state_nx = ST_REFILL;
        end
      end
      ST_REFILL: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_done) begin
          refill_we = 1'b1;
          if (cnt == WRD_W'(WORDS - 1)) begin
            last_word = 1'b1;
            state_nx  = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        done      = 1'b1;
        read_data = rd_data;
        state_nx  = rw_flag[0] ? ST_LOOKUP : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Word counter wraps to zero as the last word lands; flushed remembers a flush seen mid-refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      flushed <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != ST_REFILL) begin
        cnt     <= '0;
        flushed <= 1'b0;
      end else begin
        if (mem_done) cnt <= cnt + 1'b1;
        if (flush) flushed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) req_addr <= addr;
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a 3-cycle memory model feeds refills, a queue holds expected words.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rw_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        busy, done, flush, mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_done  = 1'b0;

  int          total = 0;
  int          bad   = 0;
  int          mcnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  logic        saw_mem  = 1'b0;
  logic        saw_busy = 1'b0;

  always #5 clk = ~clk;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rw_flag   (rw_flag),
    .addr      (addr),
    .write_data(write_data),
    .write_mask(write_mask),
    .read_data (read_data),
    .busy      (busy),
    .done      (done),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Memory answers each word request on the third cycle it is held.
  always @(posedge clk) begin
    mem_done <= 1'b0;
    if (rst || !mem_req || mem_done) mcnt <= 0;
    else if (mcnt == 1) begin
      mem_done  <= 1'b1;
      mem_rdata <= mem_word(mem_addr);
      log_q.push_back(mem_addr);
      mcnt      <= 0;
    end else mcnt <= mcnt + 1;
  end

  always @(negedge clk) begin
    if (mem_req) saw_mem = 1'b1;
    if (busy) saw_busy = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] rw, input logic [31:0] a);
    rw_flag = rw;
    addr    = a;
    exp_q.push_back(mem_word({a[31:2], 2'b00}));
    saw_mem  = 1'b0;
    saw_busy = 1'b0;
    @(posedge clk);
    #1 rw_flag = 2'b00;
  endtask

  task automatic wait_done(input string tag, input logic exp_miss, input logic chk_lat);
    int n;
    logic [31:0] e;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (done !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, read_data, e);
      chk({tag, "_miss"}, {31'b0, saw_mem}, {31'b0, exp_miss});
      if (chk_lat) chk({tag, "_lat"}, n + 1, exp_miss ? 32'd14 : 32'd1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; rw_flag = 2'b00; addr = 32'h0;
    write_data = 32'hDEAD_BEEF; write_mask = 4'hF; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_memreq", {31'b0, mem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss: four word fetches in order, then the requested word.
    log_q.delete();
    issue(2'b01, 32'h0000_0010);
    wait_done("cold", 1'b1, 1'b1);
    chk("cold_busy", {31'b0, saw_busy}, 32'd1);
    chk("cold_nfetch", log_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) chk("cold_maddr", log_q[i], 32'h10 + 32'(4 * i));

    // Back-to-back hits, second accepted during the first hit cycle.
    saw_mem = 1'b0; saw_busy = 1'b0;
    rw_flag = 2'b01; addr = 32'h14; exp_q.push_back(mem_word(32'h14));
    @(posedge clk); @(negedge clk);
    chk("b2b0_done", {31'b0, done}, 32'd1);
    chk("b2b0_data", read_data, exp_q.pop_front());
    addr = 32'h18; exp_q.push_back(mem_word(32'h18));
    @(posedge clk); @(negedge clk);
    chk("b2b1_done", {31'b0, done}, 32'd1);
    chk("b2b1_data", read_data, exp_q.pop_front());
    rw_flag = 2'b00;
    chk("b2b_busy", {31'b0, saw_busy}, 32'd0);
    chk("b2b_memreq", {31'b0, saw_mem}, 32'd0);
    @(negedge clk);

    // Same index, different tag: every access evicts the other.
    issue(2'b01, 32'h0000_0000); wait_done("conf0", 1'b1, 1'b1);
    issue(2'b01, 32'h0000_0200); wait_done("conf1", 1'b1, 1'b1);
    issue(2'b01, 32'h0000_0000); wait_done("conf2", 1'b1, 1'b1);

    // Flush during refill: responds, but the line stays invalid.
    issue(2'b01, 32'h0000_0040);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_done("flfill", 1'b1, 1'b0);
    issue(2'b01, 32'h0000_0040); wait_done("flrefetch", 1'b1, 1'b1);
    issue(2'b11, 32'h0000_0044); wait_done("rw11_hit", 1'b0, 1'b1);

    // Reset on the second refill word drops outputs without a clock edge.
    issue(2'b01, 32'h0000_0080);
    n = 0;
    @(negedge clk);
    while (!(mem_req === 1'b1 && mem_addr === 32'h84) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rstmid_reach", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_memreq", {31'b0, mem_req}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b01, 32'h0000_0080); wait_done("rstmid_refetch", 1'b1, 1'b1);

    // Write-only command is ignored.
    rw_flag = 2'b10; addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_done", {31'b0, done}, 32'd0);
      chk("wr_memreq", {31'b0, mem_req}, 32'd0);
      chk("wr_busy", {31'b0, busy}, 32'd0);
    end
    rw_flag = 2'b00;
    @(negedge clk);
    issue(2'b01, 32'h0000_0020); wait_done("wr_then_rd", 1'b1, 1'b1);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, default 32, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rw_flag  input  2  fetcher command: [0] read, [1] write, 00 idle.
REQ-006 addr  input  `addrWidth  fetch byte address; bits [1:0] ignored.
REQ-007 write_data  input  `dataWidth  unused, no effect.
REQ-008 write_mask  input  4  unused, no effect.
REQ-009 read_data  output  `instWidth  instruction word, valid only while done=1.
REQ-010 busy  output  1  cache cannot accept a request this cycle.
REQ-011 done  output  1  one-cycle pulse: read_data valid for the last accepted request.
REQ-012 flush  input  1  invalidate all lines.
REQ-013 mem_req  output  1  word-read request to memory, held until mem_done.
REQ-014 mem_addr  output  `addrWidth  word-aligned refill address.
REQ-015 mem_rdata  input  32  memory read word, valid with mem_done.
REQ-016 mem_done  input  1  one-cycle pulse: mem_rdata valid, current mem_req satisfied.

Function
REQ-017 Request accepted at a rising edge when rw_flag[0]=1 and busy=0; rw_flag=10 is ignored; rw_flag=11 is treated as a read.
REQ-018 Address split: offset addr[1:0] ignored, word addr[log2(WORDS)+1:2], index next log2(LINES) bits, tag the remaining upper bits.
REQ-019 States: IDLE, LOOKUP, REFILL, RESPOND.
REQ-020 IDLE: on an accepted request, register the address and go to LOOKUP; otherwise stay.
REQ-021 LOOKUP hit (valid and tag equal): done=1 and read_data=stored word combinationally in that cycle; busy=0; a new request may be accepted in the same cycle (stay in LOOKUP), else go to IDLE.
REQ-022 LOOKUP miss: busy=1 combinationally; next state REFILL, word counter=0.
REQ-023 REFILL: mem_req=1, mem_addr={tag,index,counter,2'b00}; on each mem_done, write mem_rdata into the line at counter and increment; on mem_done with counter=WORDS-1, set tag and go to RESPOND; busy=1 throughout.
REQ-024 Valid is set at refill completion unless a flush occurred during that refill.
REQ-025 RESPOND: done=1, busy=0, read_data=the requested word from the refilled line; next state IDLE, or LOOKUP if a request is accepted this cycle.
REQ-026 done=0 and busy=0 in IDLE; latency is hit 1 cycle, miss WORDS*mem latency + 2 cycles.
REQ-027 flush clears all valid bits at the next edge in any state; if in REFILL, the refill still completes and responds, but the line is left invalid.
REQ-028 A request presented while busy=1 is not registered; the fetcher must hold it.
REQ-029 mem_done outside REFILL is ignored.

Reset
REQ-030 rst=1 forces IDLE, all valid bits 0, counter 0, mem_req=0, done=0, busy=0 immediately, including mid-refill; data and tag arrays are not cleared.

Structure
REQ-031 `addrWidth, `instWidth, `dataWidth and the cache geometry constants (default LINES, WORDS) belong in defines.v.
REQ-032 Data/tag/valid storage is one sub-module, icache_array (combinational read, synchronous write, async valid clear).

Verification
REQ-033 Cold read addr=0x00000010 with 3-cycle memory -> busy=1, mem_addr 0x10,0x14,0x18,0x1C in order, then done=1 with word returned for 0x10.
REQ-034 Back-to-back reads 0x14 then 0x18 after line fill -> done=1 in the cycle after each acceptance, busy never 1, mem_req never 1.
REQ-035 Conflict: read 0x00000000, then 0x00000200 (same index, different tag), then 0x00000000 -> all three miss and refill.
REQ-036 flush pulse during refill of 0x40 -> refill completes with done=1; next read of 0x40 misses again.
REQ-037 rst asserted on 2nd refill word -> mem_req, busy, done drop to 0 without a clock edge; subsequent read of the same address misses.
REQ-038 rw_flag=10 at 0x20 -> no state change, done stays 0, mem_req stays 0.
